// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead add/subtract unit.
package cla_pkg;

  localparam int unsigned CLA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice widths the datapath supports; the slice must also tile the operand.
  function automatic logic slice_w_legal(input int unsigned sw, input int unsigned w);
    return ((sw == 4) || (sw == 8) || (sw == 16) || (sw == 32)) && ((w % sw) == 0);
  endfunction

endpackage

// File: rtl/cla_slice.sv
// One SLICE_W-bit carry-lookahead adder slice (combinational).
// c_msb (carry into the top bit) exists only when CLA_SEQ_OVF_EN is defined.
module cla_slice #(
  parameter int unsigned SLICE_W = 16
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic               c_msb
`endif
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;
  logic               run_g;
  logic               run_p;

  assign g = a & b;
  assign p = a ^ b;

  // Flat lookahead: every carry is a sum of generate terms gated by the
  // propagate chain above them, so no carry depends on another carry.
  always_comb begin
    c     = '0;
    run_g = 1'b0;
    run_p = 1'b1;
    c[0]  = cin;
    for (int unsigned i = 1; i <= SLICE_W; i++) begin
      run_g = 1'b0;
      run_p = 1'b1;
      for (int unsigned k = 0; k < i; k++) begin
        run_g = run_g | (run_p & g[i-1-k]);
        run_p = run_p & p[i-1-k];
      end
      c[i] = run_g | (run_p & cin);
    end
  end

  assign sum  = p ^ c[SLICE_W-1:0];
  assign cout = c[SLICE_W];
`ifdef CLA_SEQ_OVF_EN
  assign c_msb = c[SLICE_W-1];
`endif

endmodule

// File: rtl/cla_seq_addsub_64.sv
// Multi-cycle W-bit add/subtract: one SLICE_W-bit lookahead slice is reused
// LSB-first over NSLICE cycles with the carry held in a register.
// Optional signed-overflow output enabled by defining CLA_SEQ_OVF_EN.
module cla_seq_addsub_64
  import cla_pkg::*;
#(
  parameter int unsigned W       = CLA_W,
  parameter int unsigned SLICE_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned NSLICE = W / SLICE_W;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned BW     = $clog2(W);

  if (!slice_w_legal(SLICE_W, W)) begin : g_bad_slice_w
    $error("cla_seq_addsub_64: SLICE_W must be 4, 8, 16 or 32 and divide W");
  end

  state_t              state;
  state_t              state_next;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic [W-1:0]        sum_q;
  logic                carry_q;
  logic                cout_q;
  logic [IDXW-1:0]     slice_idx;
  logic                last_slice;
  logic [BW-1:0]       base;
  logic [SLICE_W-1:0]  slice_a;
  logic [SLICE_W-1:0]  slice_b;
  logic [SLICE_W-1:0]  slice_sum;
  logic                slice_cout;
`ifdef CLA_SEQ_OVF_EN
  logic                slice_cmsb;
  logic                ovf_q;
`endif

  // Slice select: bit offset of the active slice within the operands.
  always_comb begin
    base       = BW'(slice_idx) * BW'(SLICE_W);
    slice_a    = a_q[base +: SLICE_W];
    slice_b    = b_q[base +: SLICE_W];
    last_slice = (slice_idx == IDXW'(NSLICE - 1));
  end

  cla_slice #(
    .SLICE_W (SLICE_W)
  ) u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .cin   (carry_q),
    .sum   (slice_sum),
    .cout  (slice_cout)
`ifdef CLA_SEQ_OVF_EN
    ,
    .c_msb (slice_cmsb)
`endif
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = CALC;
        end
      end
      CALC: begin
        if (last_slice) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, per-slice sum/carry update and final result flags.
  // Subtract is folded into capture (b inverted, carry-in forced to 1).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      slice_idx <= '0;
`ifdef CLA_SEQ_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q       <= a;
            b_q       <= sub ? ~b : b;
            carry_q   <= sub | cin;
            slice_idx <= '0;
          end
        end
        CALC: begin
          sum_q[base +: SLICE_W] <= slice_sum;
          carry_q                <= slice_cout;
          if (last_slice) begin
            cout_q <= slice_cout;
`ifdef CLA_SEQ_OVF_EN
            ovf_q  <= slice_cout ^ slice_cmsb;
`endif
          end else begin
            slice_idx <= slice_idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef CLA_SEQ_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_addsub_64.sv
// Self-checking bench for cla_seq_addsub_64 (SLICE_W=4 when CLA_SEQ_OVF_EN is defined).
`timescale 1ns/1ps
module tb_cla_seq_addsub_64;

  localparam int unsigned W = 64;
`ifdef CLA_SEQ_OVF_EN
  localparam int unsigned SLICE_W = 4;
`else
  localparam int unsigned SLICE_W = 16;
`endif
  localparam int NSLICE = W / SLICE_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf_sig;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cla_seq_addsub_64 #(
    .W       (W),
    .SLICE_W (SLICE_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CLA_SEQ_OVF_EN
    ,
    .ovf       (ovf_sig)
`endif
  );
`ifndef CLA_SEQ_OVF_EN
  assign ovf_sig = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the add/subtract definition.
  function automatic void ref_op(input logic [63:0] x, input logic [63:0] y,
                                 input logic ci, input logic s,
                                 output logic [63:0] r, output logic co, output logic ov);
    logic [64:0] t;
    if (s) begin
      r  = x - y;
      co = (x >= y);
      ov = (x[63] != y[63]) && (r[63] != x[63]);
    end else begin
      t  = {1'b0, x} + {1'b0, y} + {64'd0, ci};
      r  = t[63:0];
      co = t[64];
      ov = (x[63] == y[63]) && (r[63] != x[63]);
    end
  endfunction

  // Transaction-level model: busy from accept until the result is taken,
  // result visible NSLICE edges after accept.
  bit          m_busy, m_valid, m_fresh;
  int          m_cyc;
  logic [63:0] e_sum;
  logic        e_cout, e_ovf;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy  = 0;
      m_valid = 0;
      m_fresh = 1;
      m_cyc   = 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        ref_op(a, b, cin, sub, e_sum, e_cout, e_ovf);
        m_busy  = 1;
        m_cyc   = 0;
        m_fresh = 0;
      end
    end else if (!m_valid) begin
      m_cyc++;
      if (m_cyc == NSLICE) m_valid = 1;
    end else if (out_ready) begin
      m_busy  = 0;
      m_valid = 0;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_sum", sum, 64'd0);
      chk("rst_cout", {63'd0, cout}, 64'd0);
    end else begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, !m_busy});
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      if (m_valid) begin
        chk("sum", sum, e_sum);
        chk("cout", {63'd0, cout}, {63'd0, e_cout});
`ifdef CLA_SEQ_OVF_EN
        chk("ovf", {63'd0, ovf_sig}, {63'd0, e_ovf});
`endif
      end else if (m_fresh) begin
        chk("idle_sum", sum, 64'd0);
        chk("idle_cout", {63'd0, cout}, 64'd0);
      end
    end
  end

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // One operation; optional backpressure for `hold` cycles after out_valid.
  task automatic op(input logic [63:0] ta, input logic [63:0] tbv, input logic tc, input logic ts,
                    input int hold, output logic [63:0] rs, output logic rc, output logic ro,
                    output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_bad++;
      $display("FAIL accept_timeout: in_ready stayed 0");
    end
    a = ta; b = tbv; cin = tc; sub = ts; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      n_bad++;
      $display("FAIL result_timeout: out_valid never rose");
    end
    rs = sum; rc = cout; ro = ovf_sig;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      @(posedge clk); #1;
      chk("bp_sum", sum, rs);
      chk("bp_cout", {63'd0, cout}, {63'd0, rc});
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin : main
    logic [63:0] rs;
    logic        rc, ro;
    int          lat;
    int          guard;

    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_sum", sum, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // all-ones + 0 + carry-in wraps to zero with carry out
    op('1, 64'd0, 1'b1, 1'b0, 0, rs, rc, ro, lat);
    chk("t1_sum", rs, 64'd0);
    chk("t1_cout", {63'd0, rc}, 64'd1);
    chk("t1_latency", 64'(lat), 64'(NSLICE));

    // 5 - 7 borrows
    op(64'd5, 64'd7, 1'b1, 1'b1, 0, rs, rc, ro, lat);
    chk("t2_sum", rs, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t2_cout", {63'd0, rc}, 64'd0);

    // x - x is zero, no borrow
    op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1, 0, rs, rc, ro, lat);
    chk("t3_sum", rs, 64'd0);
    chk("t3_cout", {63'd0, rc}, 64'd1);

    // signed overflow on max positive + 1
    op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, rs, rc, ro, lat);
    chk("t6_sum", rs, 64'h8000_0000_0000_0000);
    chk("t6_cout", {63'd0, rc}, 64'd0);
    chk("t6_latency", 64'(lat), 64'(NSLICE));
`ifdef CLA_SEQ_OVF_EN
    chk("t6_ovf", {63'd0, ro}, 64'd1);
`endif

    // backpressure for 3 cycles with stray in_valid
    op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 3, rs, rc, ro, lat);
    chk("t4_sum", rs, 64'h1234_5678_9ABC_DF00);
    chk("t4_cout", {63'd0, rc}, 64'd0);

    // reset during the second CALC cycle aborts the operation
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    a = 64'hDEAD_BEEF_0000_0001; b = 64'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("t5_out_valid", {63'd0, out_valid}, 64'd0);
    chk("t5_sum", sum, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_in_ready", {63'd0, in_ready}, 64'd1);
    op(64'd100, 64'd1, 1'b0, 1'b1, 0, rs, rc, ro, lat);
    chk("t5_next_sum", rs, 64'd99);
    chk("t5_next_cout", {63'd0, rc}, 64'd1);

    // randomized traffic with random gaps and backpressure
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 2) != 0);
      a         = pick();
      b         = pick();
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2 * NSLICE + 10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
